fetch_pc_unit: RTL and testbench

//  Fetch-stage PC owner and instruction-bus requester: consumes next-PC selection
//  (sequential +4 or redirect target) and drives the ibus request/response handshake.

---
 rtl/fetch_pc_unit.sv | 108 ++++++++++
 tb/tb_fetch_pc_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_unit
//  Description : Fetch-stage PC owner and single-outstanding ibus requester;
//                holds one fetched instruction for decode under valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic [63:0] req_addr, req_addr_n;
  logic [63:0] out_pc_r, out_pc_n;
  logic [31:0] out_instr_r, out_instr_n;
  logic [63:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc[63:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= REQ;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      out_pc_r    <= 64'd0;
      out_instr_r <= 32'd0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      req_addr    <= req_addr_n;
      out_pc_r    <= out_pc_n;
      out_instr_r <= out_instr_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    req_addr_n  = req_addr;
    out_pc_n    = out_pc_r;
    out_instr_n = out_instr_r;
    case (state)
      REQ: begin
        if (iresp_data_ok && !redirect_valid) begin
          out_instr_n = iresp_data;
          out_pc_n    = req_addr;
          state_n     = HOLD;
        end else if (iresp_data_ok && redirect_valid) begin
          pc_n       = redirect_tgt;
          req_addr_n = redirect_tgt;
        end else if (redirect_valid) begin
          // The bus request cannot be withdrawn; remember the target and
          // drain the stale response first.
          pc_n    = redirect_tgt;
          state_n = DISCARD;
        end
      end
      DISCARD: begin
        if (redirect_valid) pc_n = redirect_tgt;
        if (iresp_data_ok) begin
          req_addr_n = redirect_valid ? redirect_tgt : pc;
          state_n    = REQ;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n       = redirect_tgt;
          req_addr_n = redirect_tgt;
          state_n    = REQ;
        end else if (out_ready) begin
          pc_n       = out_pc_r + PC_STEP;
          req_addr_n = out_pc_r + PC_STEP;
          state_n    = REQ;
        end
      end
      default: state_n = REQ;
    endcase
  end

  assign ireq_valid = (state != HOLD) && !reset;
  assign ireq_addr  = req_addr;
  assign out_valid  = (state == HOLD) && !reset;
  assign out_pc     = out_pc_r;
  assign out_instr  = out_instr_r;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_pc_unit
//  Description : Directed and scoreboard bench for fetch_pc_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

  localparam logic [63:0] C_RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next falling edge: outputs are settled there
  // and inputs driven now are stable well before the next rising edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic respond(input logic [31:0] data);
    iresp_data_ok = 1'b1;
    iresp_data    = data;
    step();
    iresp_data_ok = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_pc;
    logic [31:0] word;
    int          lat;
    int          stall;
    int          budget;

    reset = 1'b1; iresp_data_ok = 1'b0; iresp_data = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 64'd0; out_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    check("rst_out_valid",  {63'd0, out_valid},  64'd0);
    check("rst_ireq_addr",  ireq_addr, C_RESET_PC);
    check("rst_out_pc",     out_pc, 64'd0);
    check("rst_out_instr",  {32'd0, out_instr}, 64'd0);

    // T1: first fetch
    reset = 1'b0;
    #1;
    check("t1_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    check("t1_ireq_addr",  ireq_addr, C_RESET_PC);
    step();
    respond(32'h0000_0013);
    check("t1_out_valid", {63'd0, out_valid}, 64'd1);
    check("t1_out_pc",    out_pc, 64'h8000_0000);
    check("t1_out_instr", {32'd0, out_instr}, 64'h13);
    check("t1_no_req",    {63'd0, ireq_valid}, 64'd0);

    // T2: decode stall
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_out_valid", {63'd0, out_valid}, 64'd1);
      check("t2_out_pc",    out_pc, 64'h8000_0000);
      check("t2_out_instr", {32'd0, out_instr}, 64'h13);
      check("t2_no_req",    {63'd0, ireq_valid}, 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_next_valid", {63'd0, ireq_valid}, 64'd1);
    check("t1_next_addr",  ireq_addr, 64'h8000_0004);
    check("t1_out_gone",   {63'd0, out_valid}, 64'd0);

    // T3: redirect while response outstanding
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    step();
    redirect_valid = 1'b0;
    check("t3_hold_addr0", ireq_addr, 64'h8000_0004);
    step();
    check("t3_hold_addr1", ireq_addr, 64'h8000_0004);
    check("t3_hold_valid", {63'd0, ireq_valid}, 64'd1);
    respond(32'hDEAD_BEEF);
    check("t3_dropped",   {63'd0, out_valid}, 64'd0);
    check("t3_new_addr",  ireq_addr, 64'h8000_1000);
    respond(32'h1111_1111);
    check("t3_out_pc",    out_pc, 64'h8000_1000);
    check("t3_out_instr", {32'd0, out_instr}, 64'h1111_1111);

    // T4: redirect beats handshake in HOLD; low bits masked
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2003; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0; out_ready = 1'b0;
    check("t4_out_valid", {63'd0, out_valid}, 64'd0);
    check("t4_addr",      ireq_addr, 64'h8000_2000);

    // T5: redirect coincident with data_ok, then double redirect in DISCARD
    redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
    respond(32'h5555_5555);
    redirect_valid = 1'b0;
    check("t5_dropped", {63'd0, out_valid}, 64'd0);
    check("t5_addr",    ireq_addr, 64'h8000_3000);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_4000;
    step();
    redirect_pc = 64'h8000_5000;
    step();
    redirect_valid = 1'b0;
    check("t5_disc_addr", ireq_addr, 64'h8000_3000);
    respond(32'h6666_6666);
    check("t5_disc_drop", {63'd0, out_valid}, 64'd0);
    check("t5_latest",    ireq_addr, 64'h8000_5000);
    respond(32'h2222_2222);
    check("t5_out_pc",    out_pc, 64'h8000_5000);
    check("t5_out_instr", {32'd0, out_instr}, 64'h2222_2222);

    // Wrap-around of the sequential PC
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr_hi", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    respond(32'h3333_3333);
    check("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("wrap_addr_0", ireq_addr, 64'd0);

    // T6: reset mid-request, then in HOLD
    reset = 1'b1;
    #1;
    check("t6_req_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    check("t6_req_out_pc",     out_pc, 64'd0);
    step();
    reset = 1'b0;
    #1;
    check("t6_restart_addr", ireq_addr, C_RESET_PC);
    respond(32'h4444_4444);
    check("t6_hold_valid", {63'd0, out_valid}, 64'd1);
    reset = 1'b1;
    #1;
    check("t6_hold_out_valid", {63'd0, out_valid}, 64'd0);
    check("t6_hold_out_instr", {32'd0, out_instr}, 64'd0);
    step();
    reset = 1'b0;
    #1;

    // Random ibus latency with in-order PC scoreboard
    exp_pc = C_RESET_PC;
    for (int n = 0; n < 24; n++) begin
      budget = 0;
      while (!ireq_valid && budget < 20) begin
        step();
        budget++;
      end
      if (!ireq_valid) check("rnd_timeout", 64'd0, 64'd1);
      check("rnd_req_addr", ireq_addr, exp_pc);
      lat = $urandom_range(0, 7);
      for (int k = 0; k < lat; k++) begin
        step();
        check("rnd_req_stable", {ireq_valid, ireq_addr[62:0]}, {1'b1, exp_pc[62:0]});
      end
      word = 32'hA000_0000 | 32'(n);
      respond(word);
      check("rnd_out_pc",    out_pc, exp_pc);
      check("rnd_out_instr", {32'd0, out_instr}, {32'd0, word});
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) step();
      check("rnd_out_valid", {63'd0, out_valid}, 64'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      exp_pc = exp_pc + 64'd4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
